// File: rtl/axi_rd_arbiter.sv
// Two-port AXI4-Lite read arbiter: instruction fetch (port 0) and LSU (port 1)
// share one downstream read master. One transaction is in flight at a time.
// R data is routed back to the issuing port. In-flight fetch responses are
// discarded on a pipeline flush.
module axi_rd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int PROT_WIDTH = 3,
  parameter int RESP_WIDTH = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [PROT_WIDTH-1:0] s0_arprot,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [RESP_WIDTH-1:0] s0_rresp,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [PROT_WIDTH-1:0] s1_arprot,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [RESP_WIDTH-1:0] s1_rresp,
  input  logic                  fetch_flush,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [PROT_WIDTH-1:0] m_axi_arprot,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [RESP_WIDTH-1:0] m_axi_rresp,
  output logic                  busy,
  output logic                  grant_id
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t                  state_reg, state_next;
  logic                    arvalid_reg, arvalid_next;
  logic [ADDR_WIDTH-1:0]   araddr_reg, araddr_next;
  logic [PROT_WIDTH-1:0]   arprot_reg, arprot_next;
  logic                    drop_reg, drop_next;
  logic                    grant_reg, grant_next;
  logic                    last_grant_reg, last_grant_next;

  logic req0, req1, win, flush_kill, sel_rready;

  // State register; reset abandons any transaction (the slave resets with us)
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      arvalid_reg    <= 1'b0;
      araddr_reg     <= '0;
      arprot_reg     <= '0;
      drop_reg       <= 1'b0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;  // so port 0 wins the first round-robin tie
    end else begin
      state_reg      <= state_next;
      arvalid_reg    <= arvalid_next;
      araddr_reg     <= araddr_next;
      arprot_reg     <= arprot_next;
      drop_reg       <= drop_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Arbitration, next-state and handshake outputs
  always_comb begin
    state_next      = state_reg;
    arvalid_next    = arvalid_reg;
    araddr_next     = araddr_reg;
    arprot_next     = arprot_reg;
    drop_next       = drop_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    s0_arready      = 1'b0;
    s1_arready      = 1'b0;
    s0_rvalid       = 1'b0;
    s1_rvalid       = 1'b0;
    m_axi_rready    = 1'b0;

    // A flush also suppresses a fetch request presented in the same cycle
    req0 = s0_arvalid & ~fetch_flush;
    req1 = s1_arvalid;
    if (req0 && req1) begin
      win = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant_reg;
    end else begin
      win = req1;
    end
    flush_kill = fetch_flush & ~grant_reg;
    sel_rready = grant_reg ? s1_rready : s0_rready;

    case (state_reg)
      IDLE: begin
        if ((req0 || req1) && !RST) begin
          s0_arready   = ~win;
          s1_arready   = win;
          araddr_next  = win ? s1_araddr : s0_araddr;
          arprot_next  = win ? s1_arprot : s0_arprot;
          arvalid_next = 1'b1;
          grant_next   = win;
          drop_next    = 1'b0;
          state_next   = ADDR;
        end
      end
      ADDR: begin
        if (flush_kill) drop_next = 1'b1;
        if (m_axi_arready) begin
          arvalid_next = 1'b0;
          state_next   = RESP;
        end
      end
      RESP: begin
        // A dropped response is drained without waiting on the port
        m_axi_rready = drop_reg | sel_rready;
        if (m_axi_rvalid && !drop_reg && !flush_kill) begin
          if (grant_reg) s1_rvalid = 1'b1;
          else           s0_rvalid = 1'b1;
        end
        if (flush_kill) drop_next = 1'b1;
        if (m_axi_rvalid && (drop_reg || sel_rready)) begin
          last_grant_next = grant_reg;
          drop_next       = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arprot  = arprot_reg;
  assign busy          = (state_reg != IDLE);
  assign grant_id      = grant_reg;
  assign s0_rdata      = m_axi_rdata;
  assign s1_rdata      = m_axi_rdata;
  assign s0_rresp      = m_axi_rresp;
  assign s1_rresp      = m_axi_rresp;

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the core's single AXI4-Lite read master port between instruction fetch (port 0) and the load/store unit (port 1).
- Accepts one request at a time and drives it onto the downstream AR channel.
- Routes the R response back to the port that issued the request.
- Drops in-flight fetch responses on a pipeline flush.
- Sits between the fetch/LSU front ends and the memory interconnect.

Parameters:
DATA_WIDTH, 32, R data width
ADDR_WIDTH, 32, AR address width
PROT_WIDTH, 3, ARPROT width
RESP_WIDTH, 4, RRESP width (codebase convention)
FIXED_PRIO, 0, 0 = round-robin; 1 = port 1 (LSU) always wins ties

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
s0_arvalid / s1_arvalid  in  1  upstream read request valid
s0_arready / s1_arready  out  1  upstream request accepted
s0_araddr / s1_araddr  in  ADDR_WIDTH  request address
s0_arprot / s1_arprot  in  PROT_WIDTH  request prot
s0_rvalid / s1_rvalid  out  1  response valid to port
s0_rready / s1_rready  in  1  port ready for response
s0_rdata / s1_rdata  out  DATA_WIDTH  response data (broadcast of m_axi_rdata)
s0_rresp / s1_rresp  out  RESP_WIDTH  response code (broadcast of m_axi_rresp)
fetch_flush  in  1  discard any outstanding or pending port-0 transaction
m_axi_arvalid  out  1  downstream AR valid (registered)
m_axi_arready  in  1  downstream AR ready
m_axi_araddr  out  ADDR_WIDTH  downstream address (registered)
m_axi_arprot  out  PROT_WIDTH  downstream prot (registered)
m_axi_rvalid  in  1  downstream R valid
m_axi_rready  out  1  downstream R ready
m_axi_rdata  in  DATA_WIDTH  downstream data
m_axi_rresp  in  RESP_WIDTH  downstream resp
busy  out  1  state != IDLE
grant_id  out  1  port owning the current transaction

Behaviour:
- Reset: all state updates on posedge CLK only.
  - While RST is high: state=IDLE, m_axi_arvalid=0, m_axi_araddr=0, m_axi_arprot=0, drop=0, grant_id=0, last_grant=1 (port 0 wins first RR tie).
  - Combinational outputs are then 0: s*_arready, s*_rvalid, m_axi_rready, busy.
- RST mid-transaction: abandon immediately, return to IDLE. The downstream slave is reset with the core.
- Single outstanding transaction. Three states: IDLE, ADDR, RESP.
- IDLE:
  - req0 = s0_arvalid & ~fetch_flush; req1 = s1_arvalid.
  - Winner:
    - only one request: that port.
    - both, FIXED_PRIO=1: port 1.
    - both, FIXED_PRIO=0: ~last_grant.
  - s{w}_arready = 1 combinationally in the same cycle; the loser's arready = 0.
  - On the handshake: latch addr/prot into m_axi_araddr/m_axi_arprot, set m_axi_arvalid=1, grant_id=w, drop=0, go to ADDR.
  - m_axi_arvalid rises the cycle after the upstream handshake.
- ADDR:
  - m_axi_arvalid, araddr and arprot held stable until m_axi_arready.
  - On m_axi_arready: clear arvalid, go to RESP.
  - All s*_arready = 0.
- RESP:
  - m_axi_rready = drop ? 1 : s{grant_id}_rready.
  - s{grant_id}_rvalid = m_axi_rvalid & ~drop & ~flush_kill, where flush_kill = fetch_flush & (grant_id==0). Other port's rvalid = 0.
  - On m_axi_rvalid & m_axi_rready: last_grant=grant_id, go to IDLE.
  - No new request is accepted in the completing cycle; earliest acceptance is the next cycle.
- Flush:
  - fetch_flush high in ADDR or RESP with grant_id==0 → drop=1 (sticky until the transaction completes).
  - If flush coincides with R completion, the response is dropped.
  - Port 1 transactions are never affected by flush.
- rresp is passed through unchanged; no error handling inside the block.
- Response latency: s_rvalid is combinational from m_axi_rvalid (0 added cycles). Minimum request-to-response is 2 cycles plus slave latency.
- m_axi_araddr/m_axi_arprot retain their last value in IDLE.

Test Plan:
- Port-0-only request:
  - Stimulus: s0 addr 0x0000_0100 prot 3'b100; slave arready=1 immediately; rvalid 2 cycles later with data 0x0000_0013, resp 0.
  - Required: s0_arready pulse in cycle N; m_axi_arvalid/araddr=0x100 in cycle N+1; s0_rvalid with 0x13; busy drops the cycle after the R handshake.
- Contention:
  - Stimulus: s0 and s1 both held valid, FIXED_PRIO=0.
  - Required: grant sequence 0,1,0,1; each next grant no earlier than 1 cycle after the R handshake.
  - With FIXED_PRIO=1: port 1 granted every time while s1_arvalid=1.
- AR backpressure:
  - Stimulus: m_axi_arready held 0 for 5 cycles.
  - Required: arvalid/araddr/arprot stable throughout; s0_arready and s1_arready stay 0; transaction completes normally afterwards.
- Flush during port-0 RESP:
  - Stimulus: fetch_flush pulsed 1 cycle; rvalid arrives 3 cycles later.
  - Required: s0_rvalid never asserts; m_axi_rready=1; return to IDLE; next s0 request accepted.
  - Same flush during a port-1 transaction: data delivered to port 1 unchanged.
- R backpressure:
  - Stimulus: s1_rready=0 while m_axi_rvalid=1 for 4 cycles.
  - Required: m_axi_rready=0; s1_rvalid held; completion in the cycle s1_rready rises.
- Reset mid-transaction:
  - Stimulus: RST asserted in RESP.
  - Required: next cycle state=IDLE, m_axi_arvalid=0, busy=0, grant_id=0; first post-reset tie grants port 0.
